// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag bit positions and default width for alu_regfile_pipe
package alu_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLA = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_regfile_pipe_seq_mul.sv
// rtl/alu_regfile_pipe_seq_mul.sv - shift-add multiplier, one multiplier bit per cycle
module seq_mul #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CW = $clog2(DATA_W);

  logic              busy;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;

  // The last multiplier bit is folded in combinationally, so the full product
  // is available during the DATA_W-th cycle after start.
  assign done    = busy && (cnt == CW'(DATA_W - 1));
  assign product = acc + (mplier[0] ? mcand : '0);

  // Load operands on start (start wins over a finishing run), else step one bit
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_regfile_pipe.sv
// rtl/alu_regfile_pipe.sv - register file + ALU with issue/execute pipeline and forwarding
module alu_regfile_pipe
  import alu_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NREGS  = 16,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic              wr_en,
  input  logic              ext_sel,
  input  logic [DATA_W-1:0] ext_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SW  = $clog2(DATA_W);
  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] regs [NREGS];

  logic              s1_valid, s1_wr_en, s1_ext;
  logic [3:0]        s1_op;
  logic [ADDR_W-1:0] s1_dst;
  logic [DATA_W-1:0] s1_ext_data, s1_a, s1_b;

  logic              s1_is_mul, s1_done, s1_writes, wb_we, accept, mul_start, mul_done;
  logic [DATA_W-1:0] mul_product, alu_res, wb_res, op_a, op_b;
  logic              alu_c, alu_v, alu_ok, wb_c, wb_v;
  logic [3:0]        wb_flags;
  logic [DATA_W:0]   wide;
  logic [SW-1:0]     shamt;

  assign s1_is_mul = !s1_ext && (s1_op == OP_MUL);
  assign s1_done   = s1_valid && (!s1_is_mul || mul_done);
  assign in_ready  = !s1_valid || s1_done;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && !ext_sel && (op == OP_MUL);
  assign shamt     = s1_b[SW-1:0];
  assign wb_we     = s1_done && s1_wr_en && s1_writes && (int'(s1_dst) < NREGS);
  assign dbg_data  = (int'(dbg_addr) < NREGS) ? regs[dbg_addr] : '0;

  seq_mul #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Operand read; a completing stage-1 write to the same register overrides the file
  always_comb begin
    op_a = (int'(src_a) < NREGS) ? regs[src_a] : '0;
    op_b = (int'(src_b) < NREGS) ? regs[src_b] : '0;
    if (wb_we && (s1_dst == src_a)) op_a = wb_res;
    if (wb_we && (s1_dst == src_b)) op_b = wb_res;
  end

  // Combinational ALU on the stage-1 operands; shifts carry out through an extra bit
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ok  = 1'b1;
    case (s1_op)
      OP_ADD: begin
        wide    = {1'b0, s1_a} + {1'b0, s1_b};
        alu_res = wide[MSB:0];
        alu_c   = wide[DATA_W];
        alu_v   = (s1_a[MSB] == s1_b[MSB]) && (alu_res[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        wide    = {1'b0, s1_a} + {1'b0, ~s1_b} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = wide[MSB:0];
        alu_c   = wide[DATA_W];
        alu_v   = (s1_a[MSB] != s1_b[MSB]) && (alu_res[MSB] != s1_a[MSB]);
      end
      OP_AND: alu_res = s1_a & s1_b;
      OP_OR:  alu_res = s1_a | s1_b;
      OP_XOR: alu_res = s1_a ^ s1_b;
      OP_NOT: alu_res = ~s1_a;
      OP_SLA: begin
        wide    = {1'b0, s1_a} << shamt;
        alu_res = wide[MSB:0];
        alu_c   = wide[DATA_W];
      end
      OP_SRA: begin
        wide    = $signed({s1_a, 1'b0}) >>> shamt;
        alu_res = wide[DATA_W:1];
        alu_c   = wide[0];
      end
      OP_SRL: begin
        wide    = {s1_a, 1'b0} >> shamt;
        alu_res = wide[DATA_W:1];
        alu_c   = wide[0];
      end
      OP_MUL: alu_res = mul_product;
      default: alu_ok = 1'b0;
    endcase
  end

  // Writeback value and flags; reserved ops leave flags alone and produce zero
  always_comb begin
    wb_res    = '0;
    wb_c      = 1'b0;
    wb_v      = 1'b0;
    s1_writes = 1'b0;
    if (s1_ext) begin
      wb_res    = s1_ext_data;
      s1_writes = 1'b1;
    end else if (alu_ok) begin
      wb_res    = alu_res;
      wb_c      = alu_c;
      wb_v      = alu_v;
      s1_writes = 1'b1;
    end
    wb_flags = flags;
    if (s1_writes) begin
      wb_flags[FLAG_Z] = (wb_res == '0);
      wb_flags[FLAG_N] = wb_res[MSB];
      wb_flags[FLAG_C] = wb_c;
      wb_flags[FLAG_V] = wb_v;
    end
  end

  // Stage 1: capture on accept, empty out when the held instruction completes
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_op       <= '0;
      s1_dst      <= '0;
      s1_wr_en    <= 1'b0;
      s1_ext      <= 1'b0;
      s1_ext_data <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
    end else if (accept) begin
      s1_valid    <= 1'b1;
      s1_op       <= op;
      s1_dst      <= dst;
      s1_wr_en    <= wr_en;
      s1_ext      <= ext_sel;
      s1_ext_data <= ext_data;
      s1_a        <= op_a;
      s1_b        <= op_b;
    end else if (s1_done) begin
      s1_valid    <= 1'b0;
    end
  end

  // Registered result/flags, one-cycle out_valid pulse and register file write
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      out_valid <= s1_done;
      if (s1_done) begin
        result <= wb_res;
        flags  <= wb_flags;
      end
      if (wb_we) regs[s1_dst] <= wb_res;
    end
  end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// tb/tb_alu_regfile_pipe.sv - self-checking bench for alu_regfile_pipe
module tb_alu_regfile_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [3:0]  src_a = '0, src_b = '0, dst = '0, dbg_addr = '0;
  logic        wr_en = 1'b0, ext_sel = 1'b0;
  logic [31:0] ext_data = '0;
  logic        out_valid;
  logic [31:0] result, dbg_data;
  logic [3:0]  flags;

  int checks = 0;
  int failures = 0;

  alu_regfile_pipe #(.DATA_W(32), .NREGS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .dst(dst), .wr_en(wr_en), .ext_sel(ext_sel),
    .ext_data(ext_data), .out_valid(out_valid), .result(result), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    int          sa, sb, sd;
    logic        we, es;
    logic [31:0] ed, res;
    logic [3:0]  fl;
  } vec_t;

  exp_t        expq[$];
  logic [31:0] mregs[16];
  logic [3:0]  mflags;
  vec_t        vt[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference ALU from the arithmetic definitions (ok=0 means reserved opcode)
  function automatic void ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output logic v, output bit ok);
    int sh;
    longint sv;
    logic [63:0] u;
    sh = int'(b % 32);
    r = '0; c = 1'b0; v = 1'b0; ok = 1'b1;
    case (o)
      4'd0: begin
        u = 64'(a) + 64'(b); r = u[31:0]; c = (u > 64'hFFFF_FFFF);
        sv = longint'($signed(a)) + longint'($signed(b));
        v = (sv > 64'sh7FFF_FFFF) || (sv < -64'sh8000_0000);
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        sv = longint'($signed(a)) - longint'($signed(b));
        v = (sv > 64'sh7FFF_FFFF) || (sv < -64'sh8000_0000);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = a << sh; c = (sh != 0) ? a[32 - sh] : 1'b0; end
      4'd7: begin r = $signed(a) >>> sh; c = (sh != 0) ? a[sh - 1] : 1'b0; end
      4'd8: begin r = a >> sh; c = (sh != 0) ? a[sh - 1] : 1'b0; end
      4'd9: r = a * b;
      default: ok = 1'b0;
    endcase
  endfunction

  // Sequential-semantics model: each accepted instruction executes completely in order
  task automatic model_exec(input logic [3:0] o, input int sa, input int sb, input int sd,
                            input logic we, input logic es, input logic [31:0] ed,
                            input bit use_exp, input logic [31:0] xr, input logic [3:0] xf,
                            input string nm);
    logic [31:0] a, b, r;
    logic c, v;
    bit ok;
    exp_t e;
    a = mregs[sa];
    b = mregs[sb];
    if (es) begin r = ed; c = 1'b0; v = 1'b0; ok = 1'b1; end
    else ref_alu(o, a, b, r, c, v, ok);
    if (ok) begin
      mflags = {v, c, r[31], (r == 32'd0)};
      if (we) mregs[sd] = r;
    end else begin
      r = '0;
    end
    e.res  = use_exp ? xr : r;
    e.fl   = use_exp ? xf : mflags;
    e.name = nm;
    expq.push_back(e);
  endtask

  task automatic issue(input logic [3:0] o, input int sa, input int sb, input int sd,
                       input logic we, input logic es, input logic [31:0] ed,
                       input bit use_exp, input logic [31:0] xr, input logic [3:0] xf,
                       input string nm);
    int w = 0;
    in_valid = 1'b1; op = o; src_a = 4'(sa); src_b = 4'(sb); dst = 4'(sd);
    wr_en = we; ext_sel = es; ext_data = ed;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL %s_accept_timeout in_ready=%b required=1", nm, in_ready);
      in_valid = 1'b0;
      return;
    end
    model_exec(o, sa, sb, sd, we, es, ed, use_exp, xr, xf, nm);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (expq.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("pending_results", 32'(expq.size()), 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mflags = '0;
    expq.delete();
  endtask

  // Each out_valid pulse must match the oldest outstanding instruction
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out_valid result=%h required=no_pulse", result);
      end else begin
        e = expq.pop_front();
        if (result !== e.res || flags !== e.fl) begin
          failures++;
          $display("FAIL %s result=%h flags=%b required result=%h flags=%b",
                   e.name, result, flags, e.res, e.fl);
        end
      end
    end
  end

  initial begin
    int lowc;
    logic [3:0] rop;
    model_reset();

    //               op     sa sb sd we    es    ext_data       result         flags
    vt[0]  = '{4'd0,  0, 0, 0, 1'b1, 1'b1, 32'd14,        32'd14,        4'h0};
    vt[1]  = '{4'd0,  0, 0, 1, 1'b1, 1'b1, 32'd25,        32'd25,        4'h0};
    vt[2]  = '{4'd0,  0, 1, 2, 1'b1, 1'b0, 32'd0,         32'd39,        4'h0};
    vt[3]  = '{4'd1,  0, 1, 3, 1'b1, 1'b0, 32'd0,         32'hFFFF_FFF5, 4'h2};
    vt[4]  = '{4'd1,  1, 0, 3, 1'b1, 1'b0, 32'd0,         32'd11,        4'h4};
    vt[5]  = '{4'd0,  0, 0, 9, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'h0};
    vt[6]  = '{4'd0,  0, 0, 10, 1'b1, 1'b1, 32'd1,        32'd1,         4'h0};
    vt[7]  = '{4'd0,  9, 10, 11, 1'b1, 1'b0, 32'd0,       32'h8000_0000, 4'hA};
    vt[8]  = '{4'd0,  0, 0, 4, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 4'h2};
    vt[9]  = '{4'd0,  0, 0, 5, 1'b1, 1'b1, 32'd4,         32'd4,         4'h0};
    vt[10] = '{4'd7,  4, 5, 12, 1'b1, 1'b0, 32'd0,        32'hF800_0000, 4'h2};
    vt[11] = '{4'd8,  4, 5, 13, 1'b1, 1'b0, 32'd0,        32'h0800_0000, 4'h0};
    vt[12] = '{4'd0,  0, 0, 14, 1'b1, 1'b1, 32'd1,        32'd1,         4'h0};
    vt[13] = '{4'd6,  4, 14, 15, 1'b1, 1'b0, 32'd0,       32'd0,         4'h5};
    vt[14] = '{4'd12, 0, 1, 2, 1'b1, 1'b0, 32'd0,         32'd0,         4'h5};
    vt[15] = '{4'd0,  0, 0, 0, 1'b0, 1'b0, 32'd0,         32'd28,        4'h0};
    vt[16] = '{4'd5,  0, 0, 6, 1'b1, 1'b0, 32'd0,         32'hFFFF_FFF1, 4'h2};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1 chk($sformatf("reset_r%0d", i), dbg_data, 32'd0);
    end

    // Back-to-back table vectors exercise forwarding on every dependent pair
    for (int i = 0; i < 17; i++)
      issue(vt[i].op, vt[i].sa, vt[i].sb, vt[i].sd, vt[i].we, vt[i].es, vt[i].ed,
            1'b1, vt[i].res, vt[i].fl, $sformatf("vec%0d", i));
    drain();
    dbg_addr = 4'd0;  #1 chk("dbg_r0", dbg_data, 32'd14);
    dbg_addr = 4'd1;  #1 chk("dbg_r1", dbg_data, 32'd25);
    dbg_addr = 4'd2;  #1 chk("dbg_r2_reserved_no_write", dbg_data, 32'd39);
    dbg_addr = 4'd3;  #1 chk("dbg_r3", dbg_data, 32'd11);
    dbg_addr = 4'd12; #1 chk("dbg_r12", dbg_data, 32'hF800_0000);
    dbg_addr = 4'd15; #1 chk("dbg_r15", dbg_data, 32'd0);

    // MUL: in_ready low for 31 cycles, dependent ADD taken in the final cycle
    issue(4'd9, 0, 1, 6, 1'b1, 1'b0, 32'd0, 1'b1, 32'd350, 4'h0, "mul_r6");
    lowc = 0;
    while (!in_ready && lowc < 100) begin
      @(negedge clk);
      if (!in_ready) lowc++;
    end
    if (!in_ready) @(negedge clk);
    chk("mul_in_ready_low_cycles", 32'(lowc), 32'd31);
    issue(4'd0, 6, 0, 7, 1'b1, 1'b0, 32'd0, 1'b1, 32'd364, 4'h0, "add_after_mul");
    drain();
    dbg_addr = 4'd6; #1 chk("dbg_r6", dbg_data, 32'd350);
    dbg_addr = 4'd7; #1 chk("dbg_r7", dbg_data, 32'd364);

    // Reset in the middle of a MUL aborts it without any write or pulse
    issue(4'd9, 0, 1, 8, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, "mul_aborted");
    repeat (10) @(negedge clk);
    chk("mul_busy_before_reset", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("post_reset_out_valid", 32'(out_valid), 32'd0);
    repeat (40) @(negedge clk);
    dbg_addr = 4'd8; #1 chk("abort_r8", dbg_data, 32'd0);
    dbg_addr = 4'd0; #1 chk("abort_r0", dbg_data, 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);

    // Randomized instruction stream against the model
    for (int i = 0; i < 8; i++)
      issue(4'd0, 0, 0, i * 2, 1'b1, 1'b1, $urandom, 1'b0, 32'd0, 4'h0, $sformatf("seed%0d", i));
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      if (rop == 4'd9 && $urandom_range(0, 3) != 0) rop = 4'd0;
      if ($urandom_range(0, 3) == 0) @(posedge clk);
      #1;
      issue(rop, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
            1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 6) == 0), $urandom,
            1'b0, 32'd0, 4'h0, $sformatf("rand%0d_op%0d", i, rop));
    end
    drain();
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1 chk($sformatf("final_r%0d", i), dbg_data, mregs[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
